// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding, the default operand width and the
// counter-width helper used to size the step counter.
package seq_divider_pkg;

  // Default operand/result width in bits
  localparam int DIV_N = 4;

  // Divider control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Ceiling log2, minimum 1, so a counter of this width can hold 0..v-1
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational iteration of the restoring division.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Forms the (N+1)-bit trial subtraction of the divisor from the partial
// remainder shifted left with the next dividend bit, and restores on borrow.
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_rr,    // partial remainder (bit N is always 0, not stored)
  input  logic         i_qmsb,  // next dividend bit shifted in
  input  logic [N-1:0] i_b,     // divisor
  output logic [N-1:0] o_rr,    // next partial remainder
  output logic         o_qbit   // quotient bit produced this step
);

  logic [N:0] w_shifted;
  logic [N:0] w_trial;

  assign w_shifted = {i_rr, i_qmsb};
  assign w_trial   = w_shifted - {1'b0, i_b};

  // Keep the difference when no borrow occurred, otherwise restore the shifted value.
  // In both cases the result is below the divisor, so it always fits in N bits.
  always_comb begin
    o_qbit = ~w_trial[N];
    o_rr   = w_trial[N] ? w_shifted[N-1:0] : w_trial[N-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Latency: N+1 edges from accepted start to the done pulse; start ignored while busy.
// Optional macro SEQ_DIVIDER_DZ_DETECT_EN: divide-by-zero short-cut and Dz flag.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         Dz
);

  localparam int CW = clog2(N);
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  div_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_div;    // captured divisor
  logic [N-1:0]  r_qs;     // dividend in, quotient out, shifting left
  logic [N-1:0]  r_rr;     // partial remainder (its bit N is provably 0)
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_r;

  logic [N-1:0]  w_rr_nxt;
  logic          w_qbit;
  logic [N-1:0]  w_qs_nxt;

  div_step #(.N(N)) u_step (
    .i_rr   (r_rr),
    .i_qmsb (r_qs[N-1]),
    .i_b    (r_div),
    .o_rr   (w_rr_nxt),
    .o_qbit (w_qbit)
  );

  assign w_qs_nxt = {r_qs[N-2:0], w_qbit};

`ifdef SEQ_DIVIDER_DZ_DETECT_EN
  logic r_dz;
  assign Dz = r_dz;
`else
  assign Dz = 1'b0;
`endif

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_qs    <= '0;
      r_rr    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
      r_dz    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // A new request is accepted both from IDLE and in the DONE cycle
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_div <= B;
            r_qs  <= A;
            r_rr  <= '0;
            r_cnt <= '0;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
            if (B == '0) begin
              // Zero divisor bypasses the iteration entirely
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_q     <= '1;
              r_r     <= A;
              r_dz    <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end
`else
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end

        // One shift-and-subtract step per cycle; the last step publishes the result
        ST_RUN: begin
          r_rr <= w_rr_nxt;
          r_qs <= w_qs_nxt;
          if (r_cnt == LAST_STEP) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_q     <= w_qs_nxt;
            r_r     <= w_rr_nxt;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
            r_dz    <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Q    = r_q;
  assign R    = r_r;

endmodule
